// File: rtl/apb_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_fifo_pkg
// Description : Register map, bit positions and status layout of the APB FIFO.
// Revision    : 1.0
// ============================================================================
package apb_fifo_pkg;

  localparam logic [3:0] CTRL_OFS   = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] DATA_OFS   = 4'h8;

  localparam int CTRL_IRQ_EN_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_OVF_BIT   = 2;
  localparam int ST_UNF_BIT   = 3;

  typedef struct packed {
    logic [7:0] count;
    logic [3:0] rsvd;
    logic       underflow;
    logic       overflow;
    logic       full;
    logic       empty;
  } status_t;

  // Register select field of a byte offset; the low two bits are don't-care.
  function automatic logic [1:0] reg_sel(input logic [3:0] ofs);
    return ofs[3:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with combinational head word and flush.
// Revision    : 1.0
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rptr];
  assign w_push_ok = push && !full && !flush;
  assign w_pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/apb_fifo_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_fifo_slave
// Description : APB completer exposing a FIFO with CTRL/STATUS/DATA registers.
// Revision    : 1.0
// ============================================================================
module apb_fifo_slave
  import apb_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic [3:0]    PADDR,
  input  logic          PWRITE,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic [DW-1:0] PWDATA,
  output logic [DW-1:0] PRDATA,
  output logic          PREADY,
  output logic          IRQ
);

  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DONE = 1'b1;

  localparam logic [1:0] c_sel_ctrl   = reg_sel(CTRL_OFS);
  localparam logic [1:0] c_sel_status = reg_sel(STATUS_OFS);
  localparam logic [1:0] c_sel_data   = reg_sel(DATA_OFS);

  logic [0:0]    r_state;
  logic [0:0]    w_next_state;
  logic          w_load;
  logic          w_complete;
  logic [1:0]    w_sel;
  logic          w_is_ctrl;
  logic          w_is_status;
  logic          w_is_data;
  logic          w_wr;
  logic          w_rd;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          r_irq_en;
  logic          r_ovf;
  logic          r_unf;
  logic [DW-1:0] w_fifo_rdata;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_count;
  status_t       w_status;
  logic [DW-1:0] w_rdata_mux;
  logic          w_unused;

  assign w_unused = ^PADDR[1:0];

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (PSEL && PENABLE) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // PRDATA is captured on the edge entering DONE; side effects on the edge leaving it.
  always_comb begin
    PREADY     = (r_state == S_DONE);
    w_load     = (r_state == S_IDLE) && PSEL && PENABLE && !PWRITE;
    w_complete = (r_state == S_DONE) && PSEL && PENABLE;
  end

  assign w_sel       = reg_sel(PADDR);
  assign w_is_ctrl   = (w_sel == c_sel_ctrl);
  assign w_is_status = (w_sel == c_sel_status);
  assign w_is_data   = (w_sel == c_sel_data);
  assign w_wr        = w_complete && PWRITE;
  assign w_rd        = w_complete && !PWRITE;
  assign w_push      = w_wr && w_is_data;
  assign w_pop       = w_rd && w_is_data;
  assign w_flush     = w_wr && w_is_ctrl && PWDATA[CTRL_FLUSH_BIT];

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .wdata (PWDATA),
    .rdata (w_fifo_rdata),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr && w_is_ctrl) r_irq_en <= PWDATA[CTRL_IRQ_EN_BIT];

      if (w_wr && w_is_status && PWDATA[ST_OVF_BIT]) r_ovf <= 1'b0;
      else if (w_push && w_full)                     r_ovf <= 1'b1;

      if (w_wr && w_is_status && PWDATA[ST_UNF_BIT]) r_unf <= 1'b0;
      else if (w_pop && w_empty)                     r_unf <= 1'b1;
    end
  end

  always_comb begin
    w_status           = '0;
    w_status.empty     = w_empty;
    w_status.full      = w_full;
    w_status.overflow  = r_ovf;
    w_status.underflow = r_unf;
    w_status.count     = 8'(w_count);
  end

  always_comb begin
    w_rdata_mux = '0;
    case (w_sel)
      c_sel_ctrl:   w_rdata_mux[CTRL_IRQ_EN_BIT] = r_irq_en;
      c_sel_status: w_rdata_mux = DW'(w_status);
      c_sel_data:   if (!w_empty) w_rdata_mux = w_fifo_rdata;
      default:      w_rdata_mux = '0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET)      PRDATA <= '0;
    else if (w_load) PRDATA <= w_rdata_mux;
  end

  assign IRQ = r_irq_en && !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_apb_fifo_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_fifo_slave
// Description : Directed table-driven bench for apb_fifo_slave.
// Revision    : 1.0
// ============================================================================
module tb_apb_fifo_slave;

  logic        PCLK;
  logic        PRESET;
  logic [3:0]  PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        IRQ;

  int checks;
  int errors;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  apb_fifo_slave #(.DEPTH(8), .DW(32)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .IRQ     (IRQ)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                     input logic chk, input logic [31:0] exp, input logic irq);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wd;
    v.chk_rd = chk; v.exp_rd = exp; v.exp_irq = irq;
    tbl.push_back(v);
  endtask

  // One APB transfer; checks the single wait state and that PREADY drops afterwards.
  task automatic xfer(input string nm, input logic wr, input logic [3:0] addr,
                      input logic [31:0] wd, input logic keep_sel, output logic [31:0] rd);
    int n;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(posedge PCLK); #1;
      n++;
    end while (!PREADY && n < 8);
    check({nm, "_waits"}, 32'(n), 32'd1);
    rd = PRDATA;
    @(posedge PCLK); #1;
    PENABLE = 1'b0;
    PSEL    = keep_sel;
    check({nm, "_ready_drop"}, {31'b0, PREADY}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    checks = 0; errors = 0;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 4'h0; PWDATA = 32'h0;

    add(0, 4'h4, 0, 1, 32'h0000_0001, 0);
    add(1, 4'h8, 32'h1234_5678, 0, 0, 0);
    add(1, 4'h8, 32'hDEAD_BEEF, 0, 0, 0);
    add(0, 4'h4, 0, 1, 32'h0000_0200, 0);
    add(0, 4'h8, 0, 1, 32'h1234_5678, 0);
    add(0, 4'h8, 0, 1, 32'hDEAD_BEEF, 0);
    add(0, 4'h4, 0, 1, 32'h0000_0001, 0);
    for (int i = 0; i < 9; i++) add(1, 4'h8, 32'(i), 0, 0, 0);
    add(0, 4'h4, 0, 1, 32'h0000_0806, 0);
    add(0, 4'h6, 0, 1, 32'h0000_0806, 0);
    for (int i = 0; i < 8; i++) add(0, 4'h8, 0, 1, 32'(i), 0);
    add(0, 4'h4, 0, 1, 32'h0000_0005, 0);
    add(1, 4'h4, 32'h0000_0004, 0, 0, 0);
    add(0, 4'h4, 0, 1, 32'h0000_0001, 0);
    add(0, 4'h8, 0, 1, 32'h0000_0000, 0);
    add(0, 4'h4, 0, 1, 32'h0000_0009, 0);
    add(1, 4'h4, 32'h0000_0003, 0, 0, 0);
    add(0, 4'h4, 0, 1, 32'h0000_0009, 0);
    add(1, 4'h4, 32'h0000_0008, 0, 0, 0);
    add(0, 4'h4, 0, 1, 32'h0000_0001, 0);
    add(1, 4'hC, 32'hFFFF_FFFF, 0, 0, 0);
    add(0, 4'hC, 0, 1, 32'h0000_0000, 0);
    add(0, 4'h0, 0, 1, 32'h0000_0000, 0);
    add(1, 4'h0, 32'h0000_0001, 0, 0, 0);
    add(0, 4'h0, 0, 1, 32'h0000_0001, 0);
    add(1, 4'h8, 32'hCAFE_BABE, 0, 0, 1);
    add(0, 4'h8, 0, 1, 32'hCAFE_BABE, 0);
    add(1, 4'h8, 32'h0000_0011, 0, 0, 1);
    add(1, 4'h8, 32'h0000_0022, 0, 0, 1);
    add(1, 4'h8, 32'h0000_0033, 0, 0, 1);
    add(0, 4'h4, 0, 1, 32'h0000_0300, 1);
    add(1, 4'h0, 32'h0000_0003, 0, 0, 0);
    add(0, 4'h4, 0, 1, 32'h0000_0001, 0);
    add(0, 4'h0, 0, 1, 32'h0000_0001, 0);

    repeat (3) @(posedge PCLK);
    #1;
    check("reset_pready", {31'b0, PREADY}, 32'd0);
    check("reset_prdata", PRDATA, 32'd0);
    check("reset_irq", {31'b0, IRQ}, 32'd0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      xfer($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, rd);
      if (tbl[i].chk_rd) check($sformatf("vec%0d_prdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, IRQ}, {31'b0, tbl[i].exp_irq});
    end

    // Back-to-back writes with PSEL held high (irq_en still 1, FIFO empty).
    xfer("b2b0", 1'b1, 4'h8, 32'hA0A0_0001, 1'b1, rd);
    xfer("b2b1", 1'b1, 4'h8, 32'hA0A0_0002, 1'b1, rd);
    xfer("b2b2", 1'b1, 4'h8, 32'hA0A0_0003, 1'b0, rd);
    check("b2b_irq", {31'b0, IRQ}, 32'd1);
    xfer("b2b_status", 1'b0, 4'h4, 0, 1'b0, rd);
    check("b2b_status_val", rd, 32'h0000_0300);

    // PSEL dropped in the PREADY cycle: no push may happen.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h8; PWDATA = 32'h5555_5555;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    check("viol_ready_hi", {31'b0, PREADY}, 32'd1);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    check("viol_ready_lo", {31'b0, PREADY}, 32'd0);
    xfer("viol_status", 1'b0, 4'h4, 0, 1'b0, rd);
    check("viol_status_val", rd, 32'h0000_0300);

    // Reset during the first ACCESS cycle of a DATA write aborts it.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h8; PWDATA = 32'h7777_7777;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("rst_abort_ready", {31'b0, PREADY}, 32'd0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    check("rst_abort_ready2", {31'b0, PREADY}, 32'd0);
    check("rst_abort_irq", {31'b0, IRQ}, 32'd0);
    xfer("rst_status", 1'b0, 4'h4, 0, 1'b0, rd);
    check("rst_status_val", rd, 32'h0000_0001);
    xfer("rst_ctrl", 1'b0, 4'h0, 0, 1'b0, rd);
    check("rst_ctrl_val", rd, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
